ks_word_serial_adder: RTL
=========================

Name: ks_word_serial_adder

Overview:
- Word-serial wide adder controller that feeds the team's N-bit parallel-prefix adder.
- Accepts one wide operand pair (W = N*SLICES bits) over a valid/ready handshake and splits it into N-bit slices.
- Adds one slice per cycle through an N-bit prefix-adder slice with carry in/out, chaining the carry in a register.
- Returns the full W-bit sum and carry-out over a second valid/ready handshake; this is the operand-staging and result-capture stage around the prefix-adder core.

Parameters:
- N, 4, slice width in bits; matches the prefix-adder core width.
- SLICES, 4, number of slices per operand; W = N*SLICES (default 16).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and carry-in present.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this cycle.
- out_sum  output  W  registered sum, modulo 2^W.
- out_cout  output  1  carry out of the top slice.
- busy  output  1  high while in RUN.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE; slice index, carry, operand and sum registers are all 0.
  - in_ready = 0, out_valid = 0, out_sum = 0, out_cout = 0, busy = 0.
  - First cycle after release: in_ready = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready: latch in_a, in_b into operand registers; carry_r <= in_cin; idx <= 0; go to RUN.
- RUN:
  - busy = 1, in_ready = 0.
  - Each cycle: slice idx = {a_r[idx*N +: N], b_r[idx*N +: N], carry_r} feeds the slice adder.
  - sum_r[idx*N +: N] <= slice sum; carry_r <= slice cout.
  - If idx == SLICES-1: go to DONE. Otherwise idx <= idx + 1.
- DONE:
  - out_valid = 1; out_sum = sum_r; out_cout = carry_r.
  - Outputs are held stable until out_ready = 1.
  - in_ready = out_ready, so the next operand pair is accepted in the same cycle the result drains.
  - out_ready && in_valid: accept the new pair and go directly to RUN (back-to-back, no IDLE bubble).
  - out_ready && !in_valid: go to IDLE.
- Latency and throughput:
  - Acceptance on edge E gives out_valid = 1 after edge E+SLICES.
  - Steady-state throughput is one result per SLICES+1 cycles.
- Arithmetic:
  - out_sum = (A + B + cin) mod 2^W.
  - out_cout = bit W of that sum.
- Boundary conditions:
  - out_sum and out_cout change only on entry to DONE. In RUN, sum_r is partially updated but not visible as valid.
  - in_valid outside an accept window is ignored. Operands are not re-sampled during RUN.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately to the reset values above; the partial result is discarded.
  - idx wraps only via reset or re-accept; no counter overflow past SLICES-1.
  - SLICES = 1 is legal: one RUN cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the W = N*SLICES localparam derivation;
  - the idx width constant, clog2(SLICES), minimum 1.
- One sub-module: ks_slice_add. It is a combinational N-bit prefix adder with cin/cout built from the team's generate/propagate cells, with cin injected as the slice's generate at position -1.
- The controller instantiates exactly one ks_slice_add.

Test Plan:
- Reset then basic add: A = 0x1234, B = 0x4321, cin = 0, accepted at edge E -> out_valid rises after edge E+4; out_sum = 0x5555, out_cout = 0; busy high for 4 cycles.
- Full carry ripple across all slices: A = 0xFFFF, B = 0x0001, cin = 0 -> out_sum = 0x0000, out_cout = 1. Also A = 0xFFFF, B = 0x0000, cin = 1 -> out_sum = 0x0000, out_cout = 1.
- Backpressure: result 0x8000+0x8000 held with out_ready = 0 for 10 cycles -> out_sum = 0x0000, out_cout = 1 stable throughout; in_ready = 0; in_valid pulses ignored.
- Back-to-back: second pair (0x00FF, 0x0F01) presented while out_ready = 1 in DONE -> accepted that cycle; next out_valid 5 cycles after the first; second result = 0x1000, cout = 0.
- Reset mid-RUN: assert rst_n = 0 at idx = 2 -> all outputs 0 immediately, state IDLE. After release, A = 0x0001, B = 0x0001 -> 0x0002.
- Random: 1000 operand pairs with random in_valid/out_ready stalls -> every result matches the reference model (A + B + cin); no lost or duplicated transactions.

Source files
------------

// File: rtl/ks_word_serial_adder_pkg.sv
// Shared types and sizing helpers for the word-serial prefix adder controller.
package ks_word_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF      = 4;
  localparam int SLICES_DEF = 4;
  localparam int W_DEF      = N_DEF * SLICES_DEF;

  function automatic int word_w(input int n, input int slices);
    return n * slices;
  endfunction

  // Slice index needs at least one bit even when SLICES = 1.
  function automatic int idx_w(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/ks_slice_add.sv
// Combinational N-bit Kogge-Stone adder; cin enters as the generate of position -1.
module ks_slice_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int M = N + 1;

  logic [M-1:0] g;
  logic [M-1:0] p;

  // Index 0 is position -1 (carry-in); index j holds bit j-1. Descending j keeps
  // the in-place update reading the previous level's values.
  always_comb begin
    g = {a_i & b_i, cin_i};
    p = {a_i ^ b_i, 1'b0};
    for (int d = 1; d < M; d = d * 2) begin
      for (int j = M - 1; j >= d; j--) begin
        g[j] = g[j] | (p[j] & g[j-d]);
        p[j] = p[j] & p[j-d];
      end
    end
    sum_o  = (a_i ^ b_i) ^ g[N-1:0];
    cout_o = g[N];
  end

endmodule

// File: rtl/ks_word_serial_adder.sv
// Word-serial wide adder: stages an operand pair, adds one N-bit slice per cycle, holds the result.
module ks_word_serial_adder
  import ks_word_serial_adder_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int SLICES = SLICES_DEF,
  localparam int W      = word_w(N, SLICES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
);

  localparam int IW = idx_w(SLICES);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [W-1:0]  res_q, res_d;
  logic          rcout_q, rcout_d;
  logic          init_q;

  logic          accept;
  logic          last;
  logic [N-1:0]  s_a, s_b, s_sum;
  logic          s_cout;

  assign accept = in_valid & in_ready;
  assign last   = (idx_q == IW'(SLICES - 1));
  assign s_a    = a_q[idx_q*N +: N];
  assign s_b    = b_q[idx_q*N +: N];

  ks_slice_add #(.N(N)) u_slice (
    .a_i    (s_a),
    .b_i    (s_b),
    .cin_i  (carry_q),
    .sum_o  (s_sum),
    .cout_o (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In DONE, in_ready follows out_ready so a fresh pair can replace the draining result.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = init_q;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    res_d   = res_q;
    rcout_d = rcout_q;
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      carry_d = in_cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q*N +: N] = s_sum;
      carry_d             = s_cout;
      if (last) begin
        res_d   = sum_d;
        rcout_d = s_cout;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Result lives in its own register so it moves only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      rcout_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      rcout_q <= rcout_d;
      init_q  <= 1'b1;
    end
  end

  assign out_sum  = res_q;
  assign out_cout = rcout_q;

endmodule
